// File: rtl/bf_pkg.sv
// Shared definitions for the bf CPU front end: opcode map, fetch states, end-of-program bit.
package bf_pkg;

  localparam logic [2:0] OP_RIGHT = 3'b000;
  localparam logic [2:0] OP_LEFT  = 3'b001;
  localparam logic [2:0] OP_INC   = 3'b010;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_LOOP  = 3'b100;
  localparam logic [2:0] OP_END   = 3'b101;
  localparam logic [2:0] OP_IN    = 3'b110;
  localparam logic [2:0] OP_OUT   = 3'b111;

  // End-of-program marker bit for the default 8-bit instruction width.
  localparam int unsigned END_BIT = 7;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    HALT
  } fetch_state_e;

endpackage

// File: rtl/bf_fetch_unit_if.sv
// Program-memory read port plus the instruction handshake towards the decoder.
interface bf_fetch_unit_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PC_WIDTH = 8
) ();

  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_valid;
  logic [WIDTH-1:0]    imem_rdata;
  logic [WIDTH-1:0]    inst;
  logic                inst_valid;
  logic                inst_ready;
  logic                data_is_zero;
  logic                skip_flag;
  logic                sp_eq_np;

  modport master (
    output imem_req, imem_addr, inst, inst_valid, skip_flag, sp_eq_np,
    input  imem_valid, imem_rdata, inst_ready, data_is_zero
  );

  modport slave (
    input  imem_req, imem_addr, inst, inst_valid, skip_flag, sp_eq_np,
    output imem_valid, imem_rdata, inst_ready, data_is_zero
  );

endinterface

// File: rtl/bf_loop_stack.sv
// Loop-return LIFO: holds the PC of each taken '['. sp is one bit wider than the index
// so full and empty are distinct.
module bf_loop_stack #(
  parameter int unsigned STACK_DEPTH = 16,
  parameter int unsigned PC_WIDTH    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [PC_WIDTH-1:0]          push_data,
  output logic [PC_WIDTH-1:0]          top,
  output logic [$clog2(STACK_DEPTH):0] sp,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned IDX_W = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = IDX_W + 1;

  logic [SP_W-1:0]     sp_q;
  logic [PC_WIDTH-1:0] mem_q [STACK_DEPTH];

  assign full  = (sp_q == SP_W'(STACK_DEPTH));
  assign empty = (sp_q == '0);
  assign sp    = sp_q;
  assign top   = mem_q[IDX_W'(sp_q - SP_W'(1))];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else if (push && !full) begin
      sp_q <= sp_q + SP_W'(1);
    end else if (pop && !empty) begin
      sp_q <= sp_q - SP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem_q[IDX_W'(sp_q)] <= push_data;
    end
  end

endmodule

// File: rtl/bf_fetch_unit.sv
// bf instruction fetch and loop control: owns the PC, fetches from program memory and
// resolves '[' / ']' with a return stack and a nest pointer for skipped loop bodies.
module bf_fetch_unit
  import bf_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  bf_fetch_unit_if.master bus,
  output logic            halted,
  output logic            err
);

  localparam int unsigned SP_W = $clog2(STACK_DEPTH) + 1;

  fetch_state_e        state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [SP_W-1:0]     np_q;
  logic [WIDTH-1:0]    inst_q;
  logic                imem_req_q, inst_valid_q, skip_q, halted_q, err_q;

  logic [PC_WIDTH-1:0] top;
  logic [SP_W-1:0]     sp;
  logic                full, empty, push, pop;

  logic                hs, is_loop, is_end, dz, sp_eq_np, fault;
  logic [PC_WIDTH-1:0] pc_base;
  logic [PC_WIDTH:0]   pc_next_ext;

  assign sp_eq_np = (sp == np_q);

  always_comb begin
    hs      = inst_valid_q && bus.inst_ready;
    is_loop = (inst_q[2:0] == OP_LOOP);
    is_end  = (inst_q[2:0] == OP_END);
    dz      = bus.data_is_zero;
    push    = hs && !skip_q && is_loop && !dz;
    pop     = hs && !skip_q && is_end && dz;
    // A taken ']' jumps to the instruction after its matching '['.
    pc_base     = (!skip_q && is_end && !dz) ? top : pc_q;
    pc_next_ext = {1'b0, pc_base} + (PC_WIDTH + 1)'(1);
    fault = hs && ((push && full) || (!skip_q && is_end && empty) || pc_next_ext[PC_WIDTH]);
  end

  bf_loop_stack #(
    .STACK_DEPTH(STACK_DEPTH),
    .PC_WIDTH   (PC_WIDTH)
  ) u_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .pop      (pop),
    .push_data(pc_q),
    .top      (top),
    .sp       (sp),
    .full     (full),
    .empty    (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FETCH;
      pc_q         <= '0;
      np_q         <= '0;
      inst_q       <= '0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
      skip_q       <= 1'b0;
      halted_q     <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          // A response only counts against our own outstanding request.
          if (!imem_req_q) begin
            imem_req_q <= 1'b1;
          end else if (bus.imem_valid) begin
            imem_req_q <= 1'b0;
            if (bus.imem_rdata[WIDTH-1]) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
            end else begin
              inst_q       <= bus.imem_rdata;
              inst_valid_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (hs) begin
            inst_valid_q <= 1'b0;
            pc_q         <= pc_next_ext[PC_WIDTH-1:0];
            if (!skip_q) begin
              if (is_loop && dz) begin
                np_q   <= sp;
                skip_q <= 1'b1;
              end
            end else if (is_loop) begin
              np_q <= np_q + SP_W'(1);
            end else if (is_end) begin
              if (sp_eq_np) skip_q <= 1'b0;
              else          np_q   <= np_q - SP_W'(1);
            end
            if (fault) begin
              state_q  <= HALT;
              halted_q <= 1'b1;
              err_q    <= 1'b1;
            end else begin
              state_q    <= FETCH;
              imem_req_q <= 1'b1;
            end
          end
        end
        HALT: begin
        end
        default: begin
          state_q  <= HALT;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.skip_flag  = skip_q;
  assign bus.sp_eq_np   = sp_eq_np;
  assign halted         = halted_q;
  assign err            = err_q;

endmodule

// File: tb/tb_bf_fetch_unit.sv
// Directed bench for bf_fetch_unit: small programs in a one-cycle-latency memory model.
module tb_bf_fetch_unit;
  import bf_pkg::*;

  localparam int unsigned WIDTH       = 8;
  localparam int unsigned PC_WIDTH    = 8;
  localparam int unsigned STACK_DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic halted, err;

  always #5 clk = ~clk;

  bf_fetch_unit_if #(.WIDTH(WIDTH), .PC_WIDTH(PC_WIDTH)) bus ();

  bf_fetch_unit #(
    .WIDTH      (WIDTH),
    .PC_WIDTH   (PC_WIDTH),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .halted(halted),
    .err   (err)
  );

  logic [WIDTH-1:0]    prog [256];
  logic [PC_WIDTH-1:0] fetch_log [$];
  logic [WIDTH-1:0]    inst_log [$];
  logic                skip_log [$];
  logic                speq_log [$];
  int                  end_cnt;
  int                  dz_thresh;
  logic                dz_default;
  int                  vectors = 0;
  int                  miscompares = 0;

  // Memory answers one cycle after it sees a request.
  always @(posedge clk) begin
    bus.imem_valid <= bus.imem_req && !bus.imem_valid;
    bus.imem_rdata <= prog[bus.imem_addr];
    if (bus.imem_req && !bus.imem_valid) fetch_log.push_back(bus.imem_addr);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      end_cnt <= 0;
    end else if (bus.inst_valid && bus.inst_ready) begin
      inst_log.push_back(bus.inst);
      skip_log.push_back(bus.skip_flag);
      speq_log.push_back(bus.sp_eq_np);
      if (bus.inst[2:0] == OP_END) end_cnt <= end_cnt + 1;
    end
  end

  // Cell is zero at a ']' once dz_thresh ']' handshakes have happened.
  assign bus.data_is_zero = (bus.inst[2:0] == OP_END) ? (end_cnt >= dz_thresh) : dz_default;

  task automatic start_prog(input logic ready, input logic dzd, input int thr);
    logic [WIDTH-1:0] end_mark;
    end_mark = '0;
    end_mark[END_BIT] = 1'b1;
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) prog[i] = end_mark;
    bus.inst_ready = ready;
    dz_default = dzd;
    dz_thresh = thr;
  endtask

  task automatic go();
    fetch_log.delete();
    inst_log.delete();
    skip_log.delete();
    speq_log.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_to_halt(input int budget);
    int n = 0;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (halted !== 1'b1) begin
      miscompares++;
      $display("FAIL halt_timeout: halted=%b after %0d cycles, want 1", halted, n);
    end
  endtask

  task automatic test_reset();
    start_prog(1'b1, 1'b0, 99);
    @(negedge clk);
    vectors++;
    if ({bus.imem_req, bus.inst_valid, bus.skip_flag, halted, err} !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_flags: req/ival/skip/halt/err=%b want 00000",
               {bus.imem_req, bus.inst_valid, bus.skip_flag, halted, err});
    end
    vectors++;
    if (bus.inst !== 8'h00 || bus.imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_regs: inst=%h addr=%h want 00 00", bus.inst, bus.imem_addr);
    end
    go();
    @(negedge clk);
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'h00) begin
      miscompares++;
      $display("FAIL first_req: req=%b addr=%h want 1 00", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_plus_out();
    start_prog(1'b1, 1'b0, 99);
    prog[0] = 8'h02;
    prog[1] = 8'h07;
    go();
    run_to_halt(100);
    vectors++;
    if (inst_log.size() != 2 || inst_log[0] !== 8'h02 || inst_log[1] !== 8'h07) begin
      miscompares++;
      $display("FAIL plus_out_insts: count=%0d first=%h want 2 insts 02,07",
               inst_log.size(), (inst_log.size() > 0) ? inst_log[0] : 8'hxx);
    end
    vectors++;
    if (fetch_log.size() != 3 || fetch_log[2] !== 8'd2) begin
      miscompares++;
      $display("FAIL plus_out_fetches: count=%0d want 3 ending at 2", fetch_log.size());
    end
    vectors++;
    if (err !== 1'b0 || bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL plus_out_end: err=%b req=%b want 0 0", err, bus.imem_req);
    end
  endtask

  task automatic test_loop_taken();
    logic [PC_WIDTH-1:0] exp_addr [8];
    exp_addr = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd3};
    start_prog(1'b1, 1'b0, 2);
    prog[0] = 8'h04;
    prog[1] = 8'h02;
    prog[2] = 8'h05;
    go();
    run_to_halt(300);
    vectors++;
    if (fetch_log.size() != 8) begin
      miscompares++;
      $display("FAIL loop_fetch_count: got %0d want 8", fetch_log.size());
    end
    for (int i = 0; i < 8 && i < fetch_log.size(); i++) begin
      vectors++;
      if (fetch_log[i] !== exp_addr[i]) begin
        miscompares++;
        $display("FAIL loop_fetch_addr[%0d]: got %0d want %0d", i, fetch_log[i], exp_addr[i]);
      end
    end
    vectors++;
    if (dut.sp !== 5'd0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_final: sp=%0d err=%b want 0 0", dut.sp, err);
    end
  endtask

  task automatic test_skip();
    start_prog(1'b1, 1'b1, 0);
    prog[0] = 8'h04;
    prog[1] = 8'h04;
    prog[2] = 8'h03;
    prog[3] = 8'h05;
    prog[4] = 8'h02;
    prog[5] = 8'h05;
    prog[6] = 8'h07;
    go();
    run_to_halt(300);
    vectors++;
    if (inst_log.size() != 7) begin
      miscompares++;
      $display("FAIL skip_count: got %0d insts want 7", inst_log.size());
    end else begin
      for (int i = 0; i < 7; i++) begin
        vectors++;
        if (skip_log[i] !== (i >= 1 && i <= 5)) begin
          miscompares++;
          $display("FAIL skip_flag[%0d]: got %b want %b", i, skip_log[i], (i >= 1 && i <= 5));
        end
      end
      vectors++;
      if (speq_log[3] !== 1'b0 || speq_log[5] !== 1'b1) begin
        miscompares++;
        $display("FAIL skip_sp_eq_np: inner=%b outer=%b want 0 1", speq_log[3], speq_log[5]);
      end
      vectors++;
      if (inst_log[6] !== 8'h07) begin
        miscompares++;
        $display("FAIL skip_last_inst: got %h want 07", inst_log[6]);
      end
    end
    vectors++;
    if (err !== 1'b0 || dut.sp !== 5'd0) begin
      miscompares++;
      $display("FAIL skip_final: err=%b sp=%0d want 0 0", err, dut.sp);
    end
  endtask

  task automatic test_overflow();
    start_prog(1'b1, 1'b0, 99);
    for (int i = 0; i < 17; i++) prog[i] = 8'h04;
    go();
    run_to_halt(300);
    vectors++;
    if (err !== 1'b1 || bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow_flags: err=%b req=%b ival=%b want 1 0 0",
               err, bus.imem_req, bus.inst_valid);
    end
    vectors++;
    if (inst_log.size() != 17 || dut.sp !== 5'd16) begin
      miscompares++;
      $display("FAIL overflow_depth: insts=%0d sp=%0d want 17 16", inst_log.size(), dut.sp);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (halted !== 1'b1 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL overflow_sticky: halted=%b err=%b want 1 1", halted, err);
    end
  endtask

  task automatic test_unmatched();
    start_prog(1'b1, 1'b0, 99);
    prog[0] = 8'h05;
    go();
    run_to_halt(100);
    vectors++;
    if (err !== 1'b1 || dut.sp !== 5'd0 || inst_log.size() != 1) begin
      miscompares++;
      $display("FAIL unmatched: err=%b sp=%0d insts=%0d want 1 0 1",
               err, dut.sp, inst_log.size());
    end
  endtask

  task automatic test_back_to_back_backpressure();
    int n = 0;
    start_prog(1'b0, 1'b0, 99);
    prog[0] = 8'h03;
    prog[1] = 8'h02;
    go();
    while (!bus.inst_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (bus.inst_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_issue_timeout: inst_valid=%b want 1", bus.inst_valid);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.inst !== 8'h03 || bus.skip_flag !== 1'b0 || bus.inst_valid !== 1'b1 ||
          bus.imem_req !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: inst=%h skip=%b ival=%b req=%b want 03 0 1 0",
                 i, bus.inst, bus.skip_flag, bus.inst_valid, bus.imem_req);
      end
    end
    bus.inst_ready = 1'b1;
    @(negedge clk);
    bus.inst_ready = 1'b0;
    vectors++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd1 || bus.inst_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_refetch: req=%b addr=%h ival=%b want 1 01 0",
               bus.imem_req, bus.imem_addr, bus.inst_valid);
    end
    // Reset lands with a read outstanding; its response arrives after release.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.imem_addr !== 8'd0 || bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_async_reset: addr=%h ival=%b req=%b want 00 0 0",
               bus.imem_addr, bus.inst_valid, bus.imem_req);
    end
    #1 rst_n = 1'b1;
    inst_log.delete();
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 8'd0) begin
      miscompares++;
      $display("FAIL bp_late_valid: ival=%b req=%b addr=%h want 0 1 00",
               bus.inst_valid, bus.imem_req, bus.imem_addr);
    end
    bus.inst_ready = 1'b1;
    run_to_halt(100);
    vectors++;
    if (inst_log.size() != 2 || inst_log[0] !== 8'h03 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL bp_rerun: insts=%0d first=%h err=%b want 2 03 0", inst_log.size(),
               (inst_log.size() > 0) ? inst_log[0] : 8'hxx, err);
    end
  endtask

  initial begin
    bus.inst_ready = 1'b0;
    dz_default = 1'b0;
    dz_thresh = 99;
    test_reset();
    test_plus_out();
    test_loop_taken();
    test_skip();
    test_overflow();
    test_unmatched();
    test_back_to_back_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bf_fetch_unit.md
Name: bf_fetch_unit

Overview:
Instruction-fetch and loop-control stage that sits directly upstream of the instruction decoder in the bf CPU. It owns the program counter and reads the program memory. It presents one instruction at a time to the decoder with skip_flag and sp_eq_np. It also resolves '[' / ']' control flow with an internal loop-return stack and a nest pointer.

Parameters:
WIDTH, 8, instruction width in bits. inst[2:0] is the opcode; inst[WIDTH-1]=1 marks end of program.
PC_WIDTH, 8, program-counter and program-memory address width.
STACK_DEPTH, 16, number of loop-return entries (power of two).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  program-memory read request
imem_addr  out  PC_WIDTH  read address; stable while imem_req=1
imem_valid  in  1  imem_rdata valid; at most one per request
imem_rdata  in  WIDTH  fetched instruction
inst  out  WIDTH  instruction presented to the decoder
inst_valid  out  1  inst, skip_flag and sp_eq_np are valid
inst_ready  in  1  downstream accepts inst this cycle
data_is_zero  in  1  current cell == 0; sampled only on handshake
skip_flag  out  1  current instruction is inside a skipped loop body
sp_eq_np  out  1  combinational: stack pointer == nest pointer
halted  out  1  program finished or error
err  out  1  stack overflow, unmatched ']' or PC wrap

Behaviour:
- Opcode map: 000 '>', 001 '<', 010 '+', 011 '-', 100 '[', 101 ']', 110 ',', 111 '.'.
- Reset values: pc=0, sp=0, np=0, state=FETCH, imem_req=0, inst_valid=0, inst=0, skip_flag=0, halted=0, err=0.
- State FETCH:
  - imem_req=1 with imem_addr=pc.
  - On imem_valid, latch imem_rdata into inst and go to ISSUE.
  - If imem_rdata[WIDTH-1]=1, go to HALT instead.
  - Minimum fetch-to-issue latency is 1 cycle after imem_valid.
- State ISSUE:
  - inst_valid=1. inst and skip_flag are held stable until inst_valid & inst_ready.
  - On the handshake, apply the control update below, then return to FETCH.
- Control update on handshake, not skipping (skip_flag=0):
  - '[' with data_is_zero=0: push pc onto stack, sp+1, pc+1.
  - '[' with data_is_zero=1: np<=sp, skip_flag<=1, pc+1. No push.
  - ']' with data_is_zero=0: pc<=stack[sp-1]+1. Stack is unchanged.
  - ']' with data_is_zero=1: pop (sp-1), pc+1.
  - Any other opcode: pc+1.
- Control update on handshake, skipping (skip_flag=1):
  - Instructions are still issued so the decoder can suppress them.
  - '[': np+1.
  - ']' with sp_eq_np=1: skip_flag<=0. The cleared value takes effect for the next instruction.
  - ']' otherwise: np-1.
  - data_is_zero is ignored. pc+1 always.
- Error conditions. Each one goes to HALT with err=1 in the cycle after the handshake:
  - push with sp==STACK_DEPTH (overflow);
  - ']' with sp==0 while not skipping (unmatched);
  - pc+1 overflowing 2^PC_WIDTH (wrap).
- State HALT:
  - halted=1, imem_req=0, inst_valid=0.
  - Sticky until reset. err is also sticky.
- Stack pointer widths:
  - sp and np are clog2(STACK_DEPTH)+1 bits wide, so full and empty are distinguishable.
  - np never underflows below sp while skipping.
- Reset asserted mid-fetch or mid-issue: all state clears immediately. A late imem_valid arriving after reset deassertion without an outstanding request is ignored.
- imem_valid arriving while not in FETCH is ignored.

Decomposition:
- Shared package bf_pkg holds:
  - opcode localparams (OP_RIGHT, OP_LEFT, OP_INC, OP_DEC, OP_LOOP, OP_END, OP_IN, OP_OUT);
  - the fetch state enum (FETCH, ISSUE, HALT);
  - the END_BIT position.
- The decoder reuses the same package.
- One sub-module is natural: bf_loop_stack. It is a STACK_DEPTH x PC_WIDTH LIFO with push, pop, top, sp, full and empty, reset-cleared pointers, and registers for storage.

Test Plan:
- Program "+.", end marker at address 2; imem_valid one cycle after each req; inst_ready tied 1 -> inst 010 then 111 issued; halted=1, err=0 after the third fetch.
- "[+]" at 0..2 with data_is_zero=0 for the first two ']' handshakes then 1 -> fetch addresses 0,1,2,1,2,1,2,3; sp back to 0 at halt.
- "[[-]+]." with data_is_zero=1 at the first '[' -> instructions 1..5 issued with skip_flag=1; sp_eq_np=0 during the inner ']' and 1 at address 5; '.' at 6 issued with skip_flag=0.
- 17 nested '[' with STACK_DEPTH=16, data nonzero -> 17th push gives halted=1, err=1, imem_req=0.
- Lone ']' at address 0 -> err=1, halted=1, no pop.
- Backpressure: inst_ready=0 for 5 cycles during ISSUE -> inst and skip_flag stable, no new imem_req; then rst_n pulsed low during FETCH -> pc=0, inst_valid=0 on the same edge.
